// File: rtl/multi_timed_counter.sv
// multi_timed_counter: NCH-channel event counter over one shared, runtime
// programmable interval. All channel totals are latched together at each
// interval end with a one-cycle valid strobe and a wrapping sequence number.
// There is no dead cycle between consecutive intervals; only an
// interval_load cycle discards its input.
// Optional build macro MULTI_TIMED_COUNTER_SATURATE_EN: saturating
// accumulators with sticky per-channel overflow flags latched to count_ovf.
// Without it, accumulators wrap and count_ovf is tied to zero.
module multi_timed_counter #(
    parameter int NCH              = 4,
    parameter int INTERVAL_WIDTH   = 24,
    parameter int CNT_WIDTH        = 25,
    parameter int INTERVAL_DEFAULT = 1000,
    parameter int SEQ_WIDTH        = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NCH-1:0]                count_in,
    input  logic [INTERVAL_WIDTH-1:0]     interval_in,
    input  logic                          interval_load,
    output logic [NCH*CNT_WIDTH-1:0]      count_out,
    output logic                          count_valid,
    output logic [SEQ_WIDTH-1:0]          count_seq,
    output logic [NCH-1:0]                count_ovf
);

    // Timer is one bit wider so it can reach 2^INTERVAL_WIDTH when interval_reg is 0.
    localparam int             TW        = INTERVAL_WIDTH + 1;
    localparam logic [TW-1:0]  TIMER_ONE = TW'(1);
    localparam logic [TW-1:0]  FULL_SPAN = TIMER_ONE << INTERVAL_WIDTH;
    localparam logic [INTERVAL_WIDTH-1:0] INTERVAL_RST = INTERVAL_WIDTH'(INTERVAL_DEFAULT);

    logic [INTERVAL_WIDTH-1:0] interval_q, interval_d;
    logic [TW-1:0]             timer_q, timer_d;
    logic [TW-1:0]             span;
    logic                      terminal;
    logic [NCH*CNT_WIDTH-1:0]  acc_q, acc_d;
    logic [NCH*CNT_WIDTH-1:0]  sum;
    logic [NCH*CNT_WIDTH-1:0]  out_q, out_d;
    logic                      valid_q, valid_d;
    logic [SEQ_WIDTH-1:0]      seq_q, seq_d;

`ifdef MULTI_TIMED_COUNTER_SATURATE_EN
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    logic [NCH-1:0]            blocked;
    logic [NCH-1:0]            ovf_acc_q, ovf_acc_d;
    logic [NCH-1:0]            ovf_out_q, ovf_out_d;
`endif

    // Effective interval length and terminal-cycle detection.
    always_comb begin
        span     = (interval_q == '0) ? FULL_SPAN : {1'b0, interval_q};
        terminal = (timer_q == span);
    end

    // Per-channel accumulator plus this cycle's input (wrapping or saturating).
    always_comb begin
        sum = '0;
`ifdef MULTI_TIMED_COUNTER_SATURATE_EN
        blocked = '0;
`endif
        for (int i = 0; i < NCH; i++) begin
`ifdef MULTI_TIMED_COUNTER_SATURATE_EN
            if (count_in[i] && (acc_q[i*CNT_WIDTH +: CNT_WIDTH] == CNT_MAX)) begin
                sum[i*CNT_WIDTH +: CNT_WIDTH] = CNT_MAX;
                blocked[i] = 1'b1;
            end else begin
                sum[i*CNT_WIDTH +: CNT_WIDTH] =
                    acc_q[i*CNT_WIDTH +: CNT_WIDTH] + CNT_WIDTH'(count_in[i]);
            end
`else
            sum[i*CNT_WIDTH +: CNT_WIDTH] =
                acc_q[i*CNT_WIDTH +: CNT_WIDTH] + CNT_WIDTH'(count_in[i]);
`endif
        end
    end

    // Next state: load beats terminal; terminal latches totals and restarts with no gap.
    always_comb begin
        interval_d = interval_q;
        timer_d    = timer_q + TIMER_ONE;
        acc_d      = sum;
        out_d      = out_q;
        valid_d    = 1'b0;
        seq_d      = seq_q;
`ifdef MULTI_TIMED_COUNTER_SATURATE_EN
        ovf_acc_d  = ovf_acc_q | blocked;
        ovf_out_d  = ovf_out_q;
`endif
        if (interval_load) begin
            interval_d = interval_in;
            timer_d    = TIMER_ONE;
            acc_d      = '0;
`ifdef MULTI_TIMED_COUNTER_SATURATE_EN
            ovf_acc_d  = '0;
`endif
        end else if (terminal) begin
            timer_d    = TIMER_ONE;
            out_d      = sum;
            acc_d      = '0;
            valid_d    = 1'b1;
            seq_d      = seq_q + SEQ_WIDTH'(1);
`ifdef MULTI_TIMED_COUNTER_SATURATE_EN
            ovf_out_d  = ovf_acc_q | blocked;
            ovf_acc_d  = '0;
`endif
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            interval_q <= INTERVAL_RST;
            timer_q    <= TIMER_ONE;
            acc_q      <= '0;
            out_q      <= '0;
            valid_q    <= 1'b0;
            seq_q      <= '0;
`ifdef MULTI_TIMED_COUNTER_SATURATE_EN
            ovf_acc_q  <= '0;
            ovf_out_q  <= '0;
`endif
        end else begin
            interval_q <= interval_d;
            timer_q    <= timer_d;
            acc_q      <= acc_d;
            out_q      <= out_d;
            valid_q    <= valid_d;
            seq_q      <= seq_d;
`ifdef MULTI_TIMED_COUNTER_SATURATE_EN
            ovf_acc_q  <= ovf_acc_d;
            ovf_out_q  <= ovf_out_d;
`endif
        end
    end

    assign count_out   = out_q;
    assign count_valid = valid_q;
    assign count_seq   = seq_q;
`ifdef MULTI_TIMED_COUNTER_SATURATE_EN
    assign count_ovf   = ovf_out_q;
`else
    assign count_ovf   = '0;
`endif

endmodule

// File: tb/tb_multi_timed_counter.sv
// tb_multi_timed_counter: directed stimulus for multi_timed_counter with a
// queue-based scoreboard. The stimulus process pushes hand-computed expected
// results (cycle, totals, sequence); a monitor pops and compares on each valid.
// A second, narrow-count instance exercises overflow (wrap or saturate,
// depending on MULTI_TIMED_COUNTER_SATURATE_EN).
module tb_multi_timed_counter;

    localparam int IW  = 24;
    localparam int IW2 = 8;

    typedef struct {
        int          cyc;
        logic [31:0] out;
        logic [7:0]  seq;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [3:0]  count_in;
    logic [IW-1:0] interval_in;
    logic        interval_load;
    logic [31:0] count_out;
    logic        count_valid;
    logic [7:0]  count_seq;
    logic [3:0]  count_ovf;

    logic [11:0] count_out2;
    logic        count_valid2;
    logic [7:0]  count_seq2;
    logic [3:0]  count_ovf2;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   n2    = 0;
    exp_t q[$];

`ifdef MULTI_TIMED_COUNTER_SATURATE_EN
    localparam logic [11:0] EXP2_OUT = 12'hE00;
    localparam logic [3:0]  EXP2_OVF = 4'b1000;
`else
    localparam logic [11:0] EXP2_OUT = 12'h400;
    localparam logic [3:0]  EXP2_OVF = 4'b0000;
`endif

    multi_timed_counter #(
        .NCH(4), .INTERVAL_WIDTH(IW), .CNT_WIDTH(8),
        .INTERVAL_DEFAULT(10), .SEQ_WIDTH(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .count_in(count_in),
        .interval_in(interval_in), .interval_load(interval_load),
        .count_out(count_out), .count_valid(count_valid),
        .count_seq(count_seq), .count_ovf(count_ovf)
    );

    multi_timed_counter #(
        .NCH(4), .INTERVAL_WIDTH(IW2), .CNT_WIDTH(3),
        .INTERVAL_DEFAULT(10), .SEQ_WIDTH(8)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .count_in(4'b1000),
        .interval_in(8'd0), .interval_load(1'b0),
        .count_out(count_out2), .count_valid(count_valid2),
        .count_seq(count_seq2), .count_ovf(count_ovf2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] pack4(input int a, input int b, input int c, input int d);
        return {8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    task automatic push(input int c, input logic [31:0] o, input logic [7:0] s);
        exp_t e;
        e.cyc = c;
        e.out = o;
        e.seq = s;
        q.push_back(e);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Scoreboard monitor for the main instance.
    always @(negedge clk) begin
        if (rst_n && count_valid) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_valid cyc=%0d out=%h seq=%0d", cyc, count_out, count_seq);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (e.cyc != cyc || count_out !== e.out || count_seq !== e.seq || count_ovf !== 4'b0) begin
                    bad++;
                    $display("FAIL sb cyc=%0d want_cyc=%0d out=%h want_out=%h seq=%0d want_seq=%0d ovf=%h want_ovf=0",
                             cyc, e.cyc, count_out, e.out, count_seq, e.seq, count_ovf);
                end
            end
        end
    end

    // Overflow-instance monitor: every full interval counts 10 on channel 3 only.
    always @(negedge clk) begin
        if (rst_n && count_valid2) begin
            n2++;
            total++;
            if (count_out2 !== EXP2_OUT || count_ovf2 !== EXP2_OVF) begin
                bad++;
                $display("FAIL ovf_inst out=%h want=%h ovf=%b want=%b", count_out2, EXP2_OUT, count_ovf2, EXP2_OVF);
            end
        end
    end

    initial begin
        int c0, l, t, u, v, r;
        rst_n         = 1'b0;
        count_in      = '0;
        interval_in   = '0;
        interval_load = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_out",   count_out,   0);
        check("rst_valid", count_valid, 0);
        check("rst_seq",   count_seq,   0);
        check("rst_ovf",   count_ovf,   0);

        // Default interval of 10, all channels high
        count_in = 4'b1111;
        rst_n    = 1'b1;
        c0 = cyc;
        for (int j = 1; j <= 3; j++) push(c0 + 10*j, pack4(10, 10, 10, 10), 8'(j));
        repeat (30) @(negedge clk);

        // Load N=4; load-cycle input must be discarded
        l = cyc;
        interval_load = 1'b1;
        interval_in   = 4;
        count_in      = 4'b1111;
        for (int j = 1; j <= 3; j++) push(l + 1 + 4*j, pack4(2, 4, 0, 0), 8'(3 + j));
        @(negedge clk);
        interval_load = 1'b0;
        for (int k = 0; k < 12; k++) begin
            count_in = {2'b00, 1'b1, (k % 2 == 0)};
            @(negedge clk);
        end

        // Load coincident with terminal cycle
        count_in = 4'b0010;
        repeat (3) @(negedge clk);
        t = cyc;
        interval_load = 1'b1;
        interval_in   = 6;
        push(t + 7, pack4(0, 6, 0, 0), 8'd7);
        @(negedge clk);
        interval_load = 1'b0;
        check("load_term_valid", count_valid, 0);
        check("load_term_hold",  count_out,   pack4(2, 4, 0, 0));
        check("load_term_seq",   count_seq,   6);
        repeat (6) @(negedge clk);

        // N=1: valid every cycle, seq wraps
        u = cyc;
        interval_load = 1'b1;
        interval_in   = 1;
        count_in      = 4'b0100;
        @(negedge clk);
        interval_load = 1'b0;
        for (int k = 0; k < 260; k++) begin
            count_in = {1'b0, 1'b1, 1'b0, (k % 3 == 0)};
            push(u + 2 + k, pack4((k % 3 == 0) ? 1 : 0, 0, 1, 0), 8'(8 + k));
            @(negedge clk);
        end

        // Load during N=1 (every cycle terminal), then reset mid-interval
        v = cyc;
        interval_load = 1'b1;
        interval_in   = 5;
        count_in      = 4'b0001;
        @(negedge clk);
        interval_load = 1'b0;
        check("n1_load_valid", count_valid, 0);
        check("n1_load_hold",  count_out,   pack4(0, 0, 1, 0));
        check("n1_load_seq",   count_seq,   11);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_out",   count_out,   0);
        check("async_valid", count_valid, 0);
        check("async_seq",   count_seq,   0);
        check("async_ovf",   count_ovf,   0);
        check("async_out2",  count_out2,  0);
        @(negedge clk);
        rst_n    = 1'b1;
        count_in = 4'b1111;
        r = cyc;
        push(r + 10, pack4(10, 10, 10, 10), 8'd1);
        push(r + 20, pack4(10, 10, 10, 10), 8'd2);
        repeat (22) @(negedge clk);

        check("pending", q.size(), 0);
        total++;
        if (n2 < 10) begin
            bad++;
            $display("FAIL ovf_inst_count actual=%0d required>=10", n2);
        end
        if (v < 0) $display("note: cycle counter negative");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
